// File: rtl/stream_fork_dynamic_buf.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fork_dynamic_buf
//  Purpose  : Registered, dynamically-masked stream fork. Holds one input
//             beat and presents it to a selected subset of N_OUP outputs.
//             The input slot frees up once every selected output has taken
//             the beat. The optional stall flag is enabled with the macro
//             STREAM_FORK_DYN_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fork_dynamic_buf #(
  parameter int unsigned N_OUP          = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_OUP-1:0]      inp_sel_i,
  output logic [N_OUP-1:0]      oup_valid_o,
  input  logic [N_OUP-1:0]      oup_ready_i,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [N_OUP-1:0]        sel_q, sel_d;
  logic [N_OUP-1:0]        done_q, done_n;

  logic [N_OUP-1:0]        hs;
  logic [N_OUP-1:0]        done_d;
  logic                    complete;
  logic                    inp_hs;
  logic                    in_hold;

  // Outputs that still owe a handshake see valid; the payload is shared.
  assign in_hold     = (state_q == HOLD);
  assign oup_valid_o = in_hold ? (sel_q & ~done_q) : '0;
  assign oup_data_o  = data_q;
  assign busy_o      = in_hold;

  // Completion looks through this cycle's output handshakes so the slot can
  // be refilled in the same cycle the last selected output accepts.
  assign hs          = oup_valid_o & oup_ready_i;
  assign done_d      = done_q | hs;
  assign complete    = ((done_d & sel_q) == sel_q);
  assign inp_ready_o = in_hold ? complete : 1'b1;
  assign inp_hs      = inp_valid_i & inp_ready_o;

  // Next-state and held-beat update; an empty mask consumes and drops a beat.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    done_n  = done_q;
    case (state_q)
      IDLE: begin
        if (inp_hs && (inp_sel_i != '0)) begin
          data_d  = inp_data_i;
          sel_d   = inp_sel_i;
          done_n  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (complete) begin
          done_n = '0;
          if (inp_hs) begin
            data_d  = inp_data_i;
            sel_d   = inp_sel_i;
            state_d = (inp_sel_i != '0) ? HOLD : IDLE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          done_n = done_d;
        end
      end
      default: begin
        state_d = IDLE;
        done_n  = '0;
      end
    endcase
  end

  // State and held-beat registers; reset drops any held beat at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      done_q  <= done_n;
    end
  end

`ifdef STREAM_FORK_DYN_TIMEOUT_EN
  localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;

  // Count stalled HOLD cycles, saturating; any completion or IDLE clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (in_hold && !complete) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      stall_cnt <= '0;
    end
  end

  assign timeout_o = (stall_cnt == CNT_MAX);
`else
  assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fork_dynamic_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fork_dynamic_buf
//  Purpose  : Directed self-checking bench for stream_fork_dynamic_buf
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fork_dynamic_buf;

  localparam int unsigned N_OUP = 2;
  localparam int unsigned DW    = 32;
`ifdef STREAM_FORK_DYN_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            inp_valid_i;
  logic            inp_ready_o;
  logic [DW-1:0]   inp_data_i;
  logic [N_OUP-1:0] inp_sel_i;
  logic [N_OUP-1:0] oup_valid_o;
  logic [N_OUP-1:0] oup_ready_i;
  logic [DW-1:0]   oup_data_o;
  logic            busy_o;
  logic            timeout_o;

  int total = 0;
  int bad   = 0;

  stream_fork_dynamic_buf #(
    .N_OUP          (N_OUP),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inp_valid_i (inp_valid_i),
    .inp_ready_o (inp_ready_o),
    .inp_data_i  (inp_data_i),
    .inp_sel_i   (inp_sel_i),
    .oup_valid_o (oup_valid_o),
    .oup_ready_i (oup_ready_i),
    .oup_data_o  (oup_data_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    inp_valid_i = 1'b0;
    inp_data_i  = '0;
    inp_sel_i   = '0;
    oup_ready_i = '0;
    #12;
    check("rst_inp_ready", 64'(inp_ready_o), 64'd1);
    check("rst_valid",     64'(oup_valid_o), 64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_data",      64'(oup_data_o),  64'd0);
    check("rst_timeout",   64'(timeout_o),   64'd0);
    rst_ni = 1'b1;
    tick();

    // Single beat, all ready
    inp_valid_i = 1'b1; inp_data_i = 32'hA5; inp_sel_i = 2'b11; oup_ready_i = 2'b11;
    #1;
    check("t1_idle_ready", 64'(inp_ready_o), 64'd1);
    check("t1_idle_valid", 64'(oup_valid_o), 64'd0);
    tick();
    inp_valid_i = 1'b0;
    #1;
    check("t1_valid", 64'(oup_valid_o), 64'b11);
    check("t1_data",  64'(oup_data_o),  64'hA5);
    check("t1_busy",  64'(busy_o),      64'd1);
    check("t1_ready", 64'(inp_ready_o), 64'd1);
    tick();
    check("t1_back_idle", 64'(busy_o), 64'd0);
    check("t1_no_valid",  64'(oup_valid_o), 64'd0);

    // Staggered acceptance
    inp_valid_i = 1'b1; inp_data_i = 32'h11; inp_sel_i = 2'b11; oup_ready_i = 2'b01;
    tick();
    inp_valid_i = 1'b0;
    #1;
    check("t2_valid0", 64'(oup_valid_o), 64'b11);
    check("t2_ready0", 64'(inp_ready_o), 64'd0);
    tick();
    check("t2_valid1", 64'(oup_valid_o), 64'b10);
    check("t2_ready1", 64'(inp_ready_o), 64'd0);
    tick();
    check("t2_valid2", 64'(oup_valid_o), 64'b10);
    check("t2_data2",  64'(oup_data_o),  64'h11);
    oup_ready_i = 2'b10;
    #1;
    check("t2_valid3", 64'(oup_valid_o), 64'b10);
    check("t2_ready3", 64'(inp_ready_o), 64'd1);
    tick();
    check("t2_idle", 64'(busy_o), 64'd0);

    // Subset mask then empty mask
    oup_ready_i = 2'b00;
    inp_valid_i = 1'b1; inp_data_i = 32'h22; inp_sel_i = 2'b10;
    tick();
    inp_valid_i = 1'b0;
    #1;
    check("t3_subset_valid", 64'(oup_valid_o), 64'b10);
    check("t3_subset_stall", 64'(inp_ready_o), 64'd0);
    oup_ready_i = 2'b10;
    #1;
    check("t3_subset_ready", 64'(inp_ready_o), 64'd1);
    tick();
    inp_valid_i = 1'b1; inp_data_i = 32'h33; inp_sel_i = 2'b00;
    #1;
    check("t3_empty_ready", 64'(inp_ready_o), 64'd1);
    tick();
    inp_valid_i = 1'b0;
    #1;
    check("t3_empty_valid", 64'(oup_valid_o), 64'd0);
    check("t3_empty_busy",  64'(busy_o),      64'd0);
    check("t3_empty_data",  64'(oup_data_o),  64'h22);

    // Back-to-back streaming
    oup_ready_i = 2'b11;
    inp_valid_i = 1'b1; inp_data_i = 32'd1; inp_sel_i = 2'b11;
    tick();
    for (int k = 2; k <= 4; k++) begin
      inp_data_i = 32'(k);
      #1;
      check("t4_valid", 64'(oup_valid_o), 64'b11);
      check("t4_data",  64'(oup_data_o),  64'(k - 1));
      check("t4_ready", 64'(inp_ready_o), 64'd1);
      check("t4_busy",  64'(busy_o),      64'd1);
      tick();
    end
    inp_valid_i = 1'b0;
    #1;
    check("t4_last_data",  64'(oup_data_o),  64'd4);
    check("t4_last_valid", 64'(oup_valid_o), 64'b11);
    tick();
    check("t4_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset while holding a beat
    inp_valid_i = 1'b1; inp_data_i = 32'h55; inp_sel_i = 2'b11; oup_ready_i = 2'b01;
    tick();
    inp_valid_i = 1'b0;
    tick();
    check("t5_pre_valid", 64'(oup_valid_o), 64'b10);
    rst_ni = 1'b0;
    #1;
    check("t5_rst_valid", 64'(oup_valid_o), 64'd0);
    check("t5_rst_busy",  64'(busy_o),      64'd0);
    check("t5_rst_ready", 64'(inp_ready_o), 64'd1);
    tick();
    rst_ni = 1'b1; oup_ready_i = 2'b11;
    tick();
    check("t5_post_valid", 64'(oup_valid_o), 64'd0);
    check("t5_post_busy",  64'(busy_o),      64'd0);

    // Stall flag: eight stalled HOLD cycles, then completion
    oup_ready_i = 2'b00;
    inp_valid_i = 1'b1; inp_data_i = 32'h77; inp_sel_i = 2'b01;
    tick();
    inp_valid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check("t6_to_low", 64'(timeout_o), 64'd0);
      tick();
    end
    check("t6_to_high",  64'(timeout_o),   64'(TO_EN));
    check("t6_hold",     64'(oup_valid_o), 64'b01);
    oup_ready_i = 2'b01;
    #1;
    check("t6_to_at_done", 64'(timeout_o),   64'(TO_EN));
    check("t6_done_ready", 64'(inp_ready_o), 64'd1);
    tick();
    check("t6_to_clear", 64'(timeout_o), 64'd0);
    check("t6_idle",     64'(busy_o),    64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
